// File: rtl/sdcard_rx_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sdcard_rx_word_fifo
//  Purpose  : Receive-side buffer in front of the SD card DMA controller.
//             Packs bytes from the DAT-line deserializer little-endian into
//             32-bit words and stores them in a DEPTH-entry show-ahead FIFO.
//  Ports    : PCLK_i / PRESETn_i        clock, async active-low reset
//             rx_byte_valid_i/rx_byte_i byte stream in, rx_block_end_i marks
//                                       the last byte of a block
//             rx_ready_o                byte acceptance (= !fifo_full)
//             flush_i                   synchronous clear of packer + FIFO
//             fifo_data_out/fifo_read   show-ahead head word and pop
//             fifo_empty/full/level     occupancy status
//             overflow_o/underflow_o    sticky errors, cleared by error_clear
//  Revision : 1.0  initial release
// ============================================================================
module sdcard_rx_word_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              PCLK_i,
    input  logic              PRESETn_i,
    input  logic              rx_byte_valid_i,
    input  logic [7:0]        rx_byte_i,
    input  logic              rx_block_end_i,
    output logic              rx_ready_o,
    input  logic              flush_i,
    output logic [31:0]       fifo_data_out,
    input  logic              fifo_read,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [ADDR_W:0]   fifo_level,
    output logic              overflow_o,
    output logic              underflow_o,
    input  logic              error_clear
);

    localparam logic [ADDR_W:0]   C_FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] C_PTR_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   C_LVL_ONE    = (ADDR_W + 1)'(1);

    // Packer state: lanes 0..2 are held here; lane 3 never needs storing
    // because the fourth byte always commits the word directly.
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q,    shift_d;
    logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [ADDR_W:0]   level_q,    level_d;
    logic              ovf_q,      ovf_d;
    logic              unf_q,      unf_d;
    logic [31:0]       mem_q [DEPTH];

    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_commit;
    logic        w_pop;
    logic [31:0] w_word;

    always_comb begin
        w_full   = (level_q == C_FULL_LEVEL);
        w_empty  = (level_q == '0);
        // Readiness comes from registered level only, so a same-cycle pop
        // never lets a byte in while full. Flush overrides both sides.
        w_accept = rx_byte_valid_i && !w_full && !flush_i;
        w_commit = w_accept && ((byte_cnt_q == 2'd3) || rx_block_end_i);
        w_pop    = fifo_read && !w_empty && !flush_i;
        // Unfilled lanes in shift_q are already zero, so OR-ing the current
        // byte into its lane yields the zero-padded word on a block end.
        w_word   = {8'h00, shift_q} | ({24'h0, rx_byte_i} << {byte_cnt_q, 3'b000});
    end

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;

        if (flush_i) begin
            byte_cnt_d = 2'd0;
            shift_d    = 24'h0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
        end else begin
            if (w_accept) begin
                if (w_commit) begin
                    byte_cnt_d = 2'd0;
                    shift_d    = 24'h0;
                end else begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = w_word[23:0];
                end
            end
            if (w_commit) begin
                wr_ptr_d = wr_ptr_q + C_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            end
            case ({w_commit, w_pop})
                2'b10:   level_d = level_q + C_LVL_ONE;
                2'b01:   level_d = level_q - C_LVL_ONE;
                default: level_d = level_q;
            endcase
        end

        // Sticky flags ignore flush; a new event beats error_clear.
        ovf_d = (ovf_q && !error_clear) || (rx_byte_valid_i && w_full);
        unf_d = (unf_q && !error_clear) || (fifo_read && w_empty);
    end

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            byte_cnt_q <= 2'd0;
            shift_q    <= 24'h0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Storage array carries no reset; contents are only observed through
    // the level-qualified read below.
    always_ff @(posedge PCLK_i) begin
        if (w_commit) begin
            mem_q[wr_ptr_q] <= w_word;
        end
    end

    always_comb begin
        fifo_data_out = w_empty ? 32'h0 : mem_q[rd_ptr_q];
        fifo_empty    = w_empty;
        fifo_full     = w_full;
        fifo_level    = level_q;
        rx_ready_o    = !w_full;
        overflow_o    = ovf_q;
        underflow_o   = unf_q;
    end

endmodule
`default_nettype wire

// File: doc/sdcard_rx_word_fifo.md
Name: sdcard_rx_word_fifo

Overview:
Receive-side data buffer that sits directly upstream of the SD card DMA controller. It accepts bytes from the SD DAT-line deserializer and packs them little-endian into 32-bit words. Words are stored in a DEPTH-entry show-ahead FIFO. The FIFO side exposes fifo_data_out / fifo_read / fifo_empty, which the DMA controller samples and pops, plus level, backpressure and sticky error status for the register block.

Parameters:
DEPTH, 16, number of 32-bit word entries; power of 2, minimum 4
ADDR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
PCLK_i  input  1  clock; all logic is on the rising edge
PRESETn_i  input  1  reset, asynchronous, active-low
rx_byte_valid_i  input  1  byte strobe from the DAT deserializer
rx_byte_i  input  8  received data byte
rx_block_end_i  input  1  marks the current byte as the last byte of the block; qualified by rx_byte_valid_i
rx_ready_o  output  1  byte acceptance; equals !fifo_full
flush_i  input  1  synchronous clear of the packer and FIFO
fifo_data_out  output  32  head word; valid whenever !fifo_empty
fifo_read  input  1  pop the head word at this clock edge
fifo_empty  output  1  no stored words
fifo_full  output  1  DEPTH words stored
fifo_level  output  ADDR_W+1  number of stored words, 0..DEPTH
overflow_o  output  1  sticky: a byte was offered while rx_ready_o was low
underflow_o  output  1  sticky: fifo_read was asserted while fifo_empty
error_clear  input  1  clears overflow_o and underflow_o

Behaviour:
- Reset (async assert, sync release): pointers, level and byte_cnt go to 0; shift register cleared; fifo_empty=1; fifo_full=0; fifo_data_out=0; rx_ready_o=1; overflow_o=0; underflow_o=0. Memory contents are don't-care.
- Byte accept: a byte is accepted when rx_byte_valid_i && rx_ready_o.
  - byte_cnt (0..3) selects the lane; byte k goes to word bits [8k+7:8k].
- Word commit: occurs on the accept edge when byte_cnt==3, or when rx_block_end_i=1.
  - The assembled word is written at wr_ptr, including the current byte.
  - Lanes not yet filled are zero.
  - byte_cnt returns to 0 and the shift register clears.
  - Otherwise byte_cnt increments.
- Write latency: a committed word is visible at fifo_data_out on the next cycle if the FIFO was empty, and fifo_empty deasserts on that same edge.
- Show-ahead read: fifo_data_out = mem[rd_ptr] when !fifo_empty, else 32'h0.
  - The DMA controller samples fifo_data_out in the same cycle it asserts fifo_read.
  - fifo_read && !fifo_empty advances rd_ptr at that edge.
- Underflow: fifo_read while fifo_empty is ignored (no pointer or level change) and sets underflow_o.
- Overflow: rx_byte_valid_i while !rx_ready_o drops the byte (byte_cnt unchanged) and sets overflow_o.
  - rx_ready_o is evaluated from the state at the start of the cycle, so a simultaneous pop does not admit a byte while full.
- Level update: push only → level+1; pop only → level-1; push and pop together → level unchanged and both pointers advance.
  - Push and pop together is legal only when the FIFO is not full (push gated) and not empty (pop gated).
  - fifo_full = (level==DEPTH); fifo_empty = (level==0).
- Pointers: ADDR_W bits; wrap naturally from DEPTH-1 to 0.
- flush_i: highest priority over byte accept and fifo_read in the same cycle.
  - Next edge: pointers, level and byte_cnt go to 0; any partial word is discarded.
  - Sticky flags are unaffected.
- error_clear: clears both sticky flags. If a new overflow or underflow event occurs in the same cycle, set wins.
- A block end with byte_cnt==0 commits a word holding one byte in bits [7:0].

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 with no block end → one word 32'h44332211; fifo_level=1; fifo_empty drops the cycle after the 4th byte.
- Bytes 0xAA,0xBB with rx_block_end_i on 0xBB → word 32'h0000BBAA; next block's first byte lands in lane 0.
- Write 16 words (DEPTH=16), then a 17th byte offered → rx_ready_o=0; byte dropped; overflow_o=1; fifo_level=16; one fifo_read then drops level to 15 and reasserts rx_ready_o.
- Continuous push/pop at level 3 across pointer wrap (write 40 words) → output order matches input order; level stays 3.
- fifo_read asserted at reset-empty state → underflow_o=1, level stays 0; error_clear pulse → underflow_o=0.
- 2 partial bytes plus 5 words stored, then flush_i together with fifo_read and a byte → level=0, byte_cnt=0, fifo_empty=1; next 4 bytes form a clean word. Repeat with PRESETn_i asserted mid-word → all outputs return to reset values immediately.
